// File: rtl/equation_result_checker.sv
// In-system checker: queues expected results in order and compares each returned result
// against the oldest expectation, reporting match/mismatch/unexpected statistics.
module equation_result_checker #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_exp_vld,
    input  logic [WIDTH-1:0]       i_exp,
    input  logic                   i_res_vld,
    input  logic [WIDTH-1:0]       i_res,
    output logic [CNT_W-1:0]       o_match_cnt,
    output logic [CNT_W-1:0]       o_mismatch_cnt,
    output logic [CNT_W-1:0]       o_unexpected_cnt,
    output logic                   o_mismatch,
    output logic [WIDTH-1:0]       o_last_exp,
    output logic [WIDTH-1:0]       o_last_act,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_pending,
    output logic                   o_idle
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [CNT_W-1:0] r_unexp_cnt;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_last_exp;
    logic [WIDTH-1:0] r_last_act;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_pop;
    logic             w_unexp;
    logic             w_push;
    logic             w_drop;
    logic             w_cmp;
    logic             w_eq;
    logic [WIDTH-1:0] w_ref;

    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == (AW+1)'(DEPTH));
        w_bypass = w_empty & i_exp_vld & i_res_vld;
        w_pop    = i_res_vld & ~w_empty;
        w_unexp  = i_res_vld & w_empty & ~i_exp_vld;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        w_push   = i_exp_vld & ~w_bypass & (~w_full | w_pop);
        w_drop   = i_exp_vld & w_full & ~w_pop;
        w_ref    = w_pop ? r_mem[r_rptr] : i_exp;
        w_cmp    = w_pop | w_bypass;
        w_eq     = (w_ref == i_res);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= i_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_unexp_cnt    <= '0;
            r_mismatch     <= 1'b0;
            r_last_exp     <= '0;
            r_last_act     <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_mismatch <= (w_cmp & ~w_eq) | w_unexp;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_cmp && w_eq && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            if (w_cmp && !w_eq) begin
                if (r_mismatch_cnt != '1) begin
                    r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                end
                r_last_exp <= w_ref;
                r_last_act <= i_res;
            end
            if (w_unexp) begin
                if (r_unexp_cnt != '1) begin
                    r_unexp_cnt <= r_unexp_cnt + CNT_W'(1);
                end
                r_last_act <= i_res;
            end
        end
    end

    assign o_match_cnt      = r_match_cnt;
    assign o_mismatch_cnt   = r_mismatch_cnt;
    assign o_unexpected_cnt = r_unexp_cnt;
    assign o_mismatch       = r_mismatch;
    assign o_last_exp       = r_last_exp;
    assign o_last_act       = r_last_act;
    assign o_overflow       = r_overflow;
    assign o_pending        = r_count;
    assign o_idle           = (r_count == '0);

endmodule

// File: tb/tb_equation_result_checker.sv
// Bench for equation_result_checker: directed test-plan steps plus random traffic, checked
// against a queue-based reference model. A second instance with tiny counters checks saturation.
module tb_equation_result_checker;

    localparam int W   = 32;
    localparam int D   = 16;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         exp_vld = 1'b0;
    logic         res_vld = 1'b0;
    logic [W-1:0] exp_d = '0;
    logic [W-1:0] res_d = '0;

    logic [CW-1:0]  a_match, a_mism, a_unexp;
    logic           a_pulse, a_ovf, a_idle;
    logic [W-1:0]   a_le, a_la;
    logic [4:0]     a_pend;
    logic [CWS-1:0] b_match, b_mism, b_unexp;
    logic           b_pulse, b_ovf, b_idle;
    logic [W-1:0]   b_le, b_la;
    logic [4:0]     b_pend;

    equation_result_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .i_exp_vld(exp_vld), .i_exp(exp_d), .i_res_vld(res_vld),
        .i_res(res_d), .o_match_cnt(a_match), .o_mismatch_cnt(a_mism),
        .o_unexpected_cnt(a_unexp), .o_mismatch(a_pulse), .o_last_exp(a_le),
        .o_last_act(a_la), .o_overflow(a_ovf), .o_pending(a_pend), .o_idle(a_idle)
    );

    equation_result_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(CWS)) u_sat (
        .clk(clk), .rst(rst), .i_exp_vld(exp_vld), .i_exp(exp_d), .i_res_vld(res_vld),
        .i_res(res_d), .o_match_cnt(b_match), .o_mismatch_cnt(b_mism),
        .o_unexpected_cnt(b_unexp), .o_mismatch(b_pulse), .o_last_exp(b_le),
        .o_last_act(b_la), .o_overflow(b_ovf), .o_pending(b_pend), .o_idle(b_idle)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ordered list of outstanding expectations plus raw event counts
    logic [W-1:0] q[$];
    int           m_match, m_mism, m_unexp;
    bit           m_pulse, m_ovf;
    logic [W-1:0] m_le, m_la;

    function automatic logic [63:0] sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_match = 0; m_mism = 0; m_unexp = 0;
        m_pulse = 0; m_ovf = 0; m_le = '0; m_la = '0;
    endtask

    task automatic model_cmp(input logic [W-1:0] e, input logic [W-1:0] r);
        if (e == r) begin
            m_match++;
        end else begin
            m_mism++; m_pulse = 1; m_le = e; m_la = r;
        end
    endtask

    task automatic model_step(input bit ev, input logic [W-1:0] e, input bit rv,
                              input logic [W-1:0] r);
        bit byp;
        byp = 0;
        m_pulse = 0;
        if (rv) begin
            if (q.size() > 0) model_cmp(q.pop_front(), r);
            else if (ev) begin byp = 1; model_cmp(e, r); end
            else begin m_unexp++; m_pulse = 1; m_la = r; end
        end
        if (ev && !byp) begin
            if (q.size() < D) q.push_back(e);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        check("pending", 64'(a_pend), 64'(q.size()));
        check("idle", 64'(a_idle), 64'(q.size() == 0));
        check("match_cnt", 64'(a_match), sat(m_match, CW));
        check("mismatch_cnt", 64'(a_mism), sat(m_mism, CW));
        check("unexpected_cnt", 64'(a_unexp), sat(m_unexp, CW));
        check("mismatch", 64'(a_pulse), 64'(m_pulse));
        check("last_exp", 64'(a_le), 64'(m_le));
        check("last_act", 64'(a_la), 64'(m_la));
        check("overflow", 64'(a_ovf), 64'(m_ovf));
        check("sat_match_cnt", 64'(b_match), sat(m_match, CWS));
        check("sat_mismatch_cnt", 64'(b_mism), sat(m_mism, CWS));
        check("sat_unexpected_cnt", 64'(b_unexp), sat(m_unexp, CWS));
    endtask

    task automatic step(input bit ev, input logic [W-1:0] e, input bit rv, input logic [W-1:0] r);
        @(negedge clk);
        rst = 1'b0; exp_vld = ev; exp_d = e; res_vld = rv; res_d = r;
        @(posedge clk);
        model_step(ev, e, rv, r);
        #1;
        check_all();
    endtask

    // Inputs are driven active during reset to confirm they are ignored
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; exp_vld = 1'b1; res_vld = 1'b1; exp_d = $urandom; res_d = $urandom;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        logic [W-1:0] r;
        bit           ev, rv;
        model_reset();
        do_reset();
        check("reset_idle", 64'(a_idle), 64'd1);

        // In-order matching
        step(1, 5, 0, 0);
        step(1, -7, 0, 0);
        step(1, 100, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 1, -7);
        step(0, 0, 1, 100);
        check("inorder_match", 64'(a_match), 64'd3);
        check("inorder_idle", 64'(a_idle), 64'd1);

        // Mismatch capture
        step(1, 42, 0, 0);
        step(0, 0, 1, 43);
        check("mism_pulse", 64'(a_pulse), 64'd1);
        check("mism_last_exp", 64'(a_le), 64'd42);
        check("mism_last_act", 64'(a_la), 64'd43);
        step(0, 0, 0, 0);
        check("mism_pulse_end", 64'(a_pulse), 64'd0);

        // Unexpected result, then zero-latency bypass
        do_reset();
        step(0, 0, 1, 32'hFFFF_FFFF);
        check("unexp_cnt", 64'(a_unexp), 64'd1);
        check("unexp_last_act", 64'(a_la), 64'hFFFF_FFFF);
        check("unexp_last_exp", 64'(a_le), 64'd0);
        step(1, 9, 1, 9);
        check("bypass_match", 64'(a_match), 64'd1);
        check("bypass_pending", 64'(a_pend), 64'd0);

        // Full FIFO and overflow
        do_reset();
        for (int i = 0; i <= 16; i++) step(1, W'(i), 0, 0);
        check("full_pending", 64'(a_pend), 64'd16);
        check("full_overflow", 64'(a_ovf), 64'd1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, W'(i));
        check("drain_match", 64'(a_match), 64'd16);
        step(0, 0, 1, 16);
        check("dropped_unexp", 64'(a_unexp), 64'd1);
        for (int i = 0; i < 16; i++) step(1, W'(100 + i), 0, 0);
        step(1, 200, 1, 100);
        check("full_pushpop_pending", 64'(a_pend), 64'd16);
        check("full_pushpop_ovf", 64'(a_ovf), 64'd1);

        // Reset mid-operation, then 40 transactions wrapping the pointers
        do_reset();
        for (int i = 0; i < 3; i++) step(1, W'(i + 7), 0, 0);
        do_reset();
        check("midrst_match", 64'(a_match), 64'd0);
        check("midrst_pending", 64'(a_pend), 64'd0);
        check("midrst_ovf", 64'(a_ovf), 64'd0);
        step(1, 1000, 0, 0);
        for (int i = 1; i < 40; i++) step(1, W'(1000 + i), 1, W'(999 + i));
        step(0, 0, 1, 1039);
        check("wrap_match", 64'(a_match), 64'd40);
        check("wrap_mism", 64'(a_mism), 64'd0);

        // Random traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                ev = ($urandom_range(99) < 55);
                rv = ($urandom_range(99) < 50);
                r  = $urandom_range(7);
                if (q.size() > 0) r = q[0];
                if ($urandom_range(3) == 0) r = $urandom;
                step(ev, W'($urandom_range(7)), rv, r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/equation_result_checker.md
# equation_result_checker

Synthesizable in-system result checker for the equation datapath. Sits beside the equation unit. On every argument-valid cycle it takes the expected result from the stimulus side and queues it in order. It compares each `res_vld` result from the equation unit against the oldest queued expectation. Match, mismatch and unexpected-result statistics go to status outputs, so self-check works on FPGA without a simulator scoreboard.

## Interface
- `WIDTH`, 32, data width of expected and actual results (signed two's complement, compared bitwise)
- `DEPTH`, 16, expectation FIFO depth; power of two, at least 2
- `CNT_W`, 16, width of the statistic counters
- `clk`  in  1  clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `exp_vld`  in  1  expected result valid; asserted in the same cycle as the equation unit's `arg_vld`
- `exp`  in  WIDTH  expected result for that argument set
- `res_vld`  in  1  result valid from the equation unit
- `res`  in  WIDTH  result from the equation unit
- `match_cnt`  out  CNT_W  number of results equal to their expectation; saturating
- `mismatch_cnt`  out  CNT_W  number of results differing from their expectation; saturating
- `unexpected_cnt`  out  CNT_W  number of results arriving with no expectation available; saturating
- `mismatch`  out  1  one-cycle pulse per mismatch or unexpected result
- `last_exp`, `last_act`  out  WIDTH each  expected and actual values of the most recent mismatch; actual only for an unexpected result
- `overflow`  out  1  sticky; an expectation was dropped because the FIFO was full
- `pending`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `idle`  out  1  high when `pending == 0`

## Operation
- **Reset:** while `rst` is high, all of the following are held at 0 and the FIFO is flushed: read/write pointers, occupancy, every counter, `mismatch`, `last_exp`, `last_act`, `overflow`. `idle` is 1. Inputs are ignored while `rst` is high.
- **Reset mid-operation:** queued expectations are discarded. A result arriving in the first cycle after reset is treated as unexpected if no `exp_vld` accompanies it.
- **Push:** when `exp_vld` is high, `exp` is written at the write pointer. The write pointer then wraps modulo DEPTH.
- **Pop and compare:** when `res_vld` is high and the FIFO is non-empty, `res` is compared with the head entry and the read pointer advances, wrapping modulo DEPTH.
  - Equal: `match_cnt` increments.
  - Not equal: `mismatch_cnt` increments, `mismatch` pulses, and `last_exp`/`last_act` capture the head entry and `res`.
- **Bypass (empty FIFO):** if the FIFO is empty and `exp_vld` and `res_vld` are both high, `res` is compared directly against `exp` and nothing is stored. This is the zero-latency case.
- **Unexpected result:** if `res_vld` is high, the FIFO is empty and `exp_vld` is low:
  - `unexpected_cnt` increments and `mismatch` pulses;
  - `last_act` takes `res`; `last_exp` is unchanged.
- **Push + pop, non-empty FIFO:** both happen in the same cycle and occupancy is unchanged. This also applies when the FIFO is full: the push is accepted and nothing is dropped.
- **Push while full, no pop:** `exp` is dropped, `overflow` is set and stays set until reset, and occupancy stays at DEPTH.
- **Counters:** each counter saturates at 2^CNT_W-1 and holds there.
- **Comparison:** bitwise over all WIDTH bits; sign is irrelevant.

## Timing
- Registered outputs update on the edge that samples the inputs: `match_cnt`, `mismatch_cnt`, `unexpected_cnt`, `mismatch`, `last_exp`, `last_act`, `overflow`, `pending`.
- Latency is 1 cycle from input to status. `idle` is derived combinationally from `pending`.
- `mismatch` is high for exactly one cycle per offending result. Back-to-back offending results give back-to-back pulses.
- A value pushed in cycle N is available at the FIFO head from cycle N+1.
- There is no backpressure: `exp_vld` and `res_vld` may be high every cycle.

## Test plan
- **In-order matching:** reset, then push expectations 5, -7, 100 on three consecutive cycles; two cycles later return 5, -7, 100 on consecutive `res_vld` cycles.
  - Required: `match_cnt=3`, `mismatch_cnt=0`, `mismatch` never pulses, `pending` returns to 0 and `idle=1`.
- **Mismatch capture:** expect 42, return 43.
  - Required: `mismatch_cnt=1` and a one-cycle `mismatch` pulse one cycle after `res_vld`; `last_exp=42`, `last_act=43`; `pending=0`.
- **Unexpected result:** after reset with an empty FIFO, assert `res_vld` with `res=-1` and `exp_vld` low.
  - Required: `unexpected_cnt=1`, `mismatch` pulses, `last_act=32'hFFFFFFFF`, `last_exp=0`.
- **Bypass:** with an empty FIFO, drive `exp_vld` with `exp=9` and `res_vld` with `res=9` in the same cycle.
  - Required: `match_cnt=1` and `pending` stays 0.
- **Full FIFO (DEPTH=16):**
  - Push 17 values 0..16 with no results: `pending=16` and `overflow=1`.
  - Return 0..15: 16 matches, `pending=0`.
  - Return 16: `unexpected_cnt=1`.
  - Refill to full, then push and pop in the same cycle: `overflow` unchanged and `pending` stays 16.
- **Reset mid-operation and wrap:**
  - Push 3 expectations, assert `rst` for 1 cycle: all counters are 0, `pending=0`, `overflow=0`.
  - Then run 40 matched transactions (pointer wrap twice): `match_cnt=40`, no mismatches.
